piano_mode_sequencer: RTL and testbench
=======================================

# piano_mode_sequencer

Parametrised top-level mode sequencer for the digital piano. It replaces the fixed five-mode controller with a registered state machine over `N_MODES` mode engines and a synchronous key-remap learning sequence. It also provides a per-mode song/difficulty selection stage and the shared system tick. It sits between the debounced board inputs and the mode engines (Freemode, Automode, Stdymode, Playmode) and drives the muxed LED and buzzer outputs.

## Interface
Parameters:
- `N_MODES`, 4: number of mode engines; `note_key[i]` selects mode i.
- `NEEDS_SONG`, 4'b1110: bit i set means mode i passes through SELECT.
- `NOTE_KEYS`, 7: note key count; must be greater than `N_MODES`.
- `N_SONGS`, 2: selectable songs; song code 0 means none.
- `DIFF_MAX`, 6: difficulty upper bound.
- `TICK_DIV`, 100000: `clk` cycles per system tick.
- `CLOCK_BITS`, 32: width of `sys_clock`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `submit`, `cancel`, `oct_up`, `oct_down`  in  1 each  debounced levels.
- `note_key`  in  `NOTE_KEYS`  physical note keys.
- `length_key`  in  `NOTE_KEYS`  length/mod keys.
- `remap_clear`  in  1  level; restores the identity map while in REMAP.
- `mode_buzzer`  in  `N_MODES`  per-engine buzzer.
- `mode_led`  in  `N_MODES*NOTE_KEYS`  per-engine LEDs; engine i occupies slice i.
- `cue_buzzer`  in  1  Sound output for the remap cue.
- `mode_en`  out  `N_MODES`  one-hot engine enable.
- `song`  out  `$clog2(N_SONGS+1)`  selected song.
- `difficulty`  out  `$clog2(DIFF_MAX+1)`  difficulty level.
- `play_mod`  out  2  length-key mode.
- `trans_note`  out  `NOTE_KEYS`  remapped note keys.
- `cue_req`  out  1  one-cycle cue pulse.
- `cue_idx`  out  `$clog2(NOTE_KEYS)`  cue note index.
- `state`  out  2  current state, for the menu display.
- `sys_clock`  out  `CLOCK_BITS`  system tick count.
- `led`  out  `NOTE_KEYS`  muxed LEDs.
- `buzzer`  out  1  muxed buzzer.

## Operation
- Input pulses: a one-flop rising-edge detect on `submit`, `cancel`, `oct_up` and `oct_down` gives a one-cycle pulse per press.
- Key decode: a key press is valid only when `note_key` is one-hot. Non-one-hot input on a submit is ignored.
- States: MENU=0, SELECT=1, RUN=2, REMAP=3.
- Cancel: a cancel pulse in any state other than MENU goes to MENU, clears `mode_en` and `song`, and takes priority over a same-cycle submit.
- MENU, submit with key i < `N_MODES`: sets mode=i. If `NEEDS_SONG[i]`, go to SELECT with difficulty=`DIFF_MAX/2`; otherwise go to RUN.
- MENU, submit with key `N_MODES`: go to REMAP with cnt=0 and the assigned mask cleared.
- MENU, any other submit: ignored.
- SELECT, octave pulses: `oct_up` increments difficulty, `oct_down` decrements it. Difficulty saturates at 0 and `DIFF_MAX`. Both pulses in the same cycle: no change.
- SELECT, submit with key j < `N_SONGS`: song=j+1. `play_mod`=k if `length_key` is one-hot at bit k<4, else 0. Then go to RUN.
- RUN: `mode_en[mode]`=1. `led` and `buzzer` take slice `mode` of `mode_led` / `mode_buzzer`.
- MENU/SELECT outputs: `led` shows difficulty as one-hot (`1<<difficulty`) in SELECT and 0 in MENU. `buzzer`=0.
- REMAP, submit with key p not yet in the assigned mask:
  - write table[p]=cnt and set the assigned-mask bit for p;
  - pulse `cue_req` with `cue_idx`=cnt;
  - increment cnt.
- REMAP, submit with an already-assigned key: no write, no cue.
- REMAP completion: when cnt reaches `NOTE_KEYS`, go to MENU on the next cycle.
- REMAP outputs: `buzzer`=`cue_buzzer`, `led`=assigned mask.
- REMAP, `remap_clear` high: table returns to identity, go to MENU.
- REMAP, cancel: go to MENU; entries already written are kept.
- Remap lookup: `trans_note` = OR over every pressed key p of `1<<table[p]`.
- System tick: `sys_clock` increments once every exactly `TICK_DIV` cycles, using a divider counting 0..`TICK_DIV`-1. Wraps modulo 2^`CLOCK_BITS`.

## Timing
- Latency: all outputs are registered. A submit edge at cycle t, meaning `submit` is first sampled high at t, produces pulse t+1, state change t+2, and `mode_en`/`cue_req` at t+2.
- `trans_note` lags `note_key` by 1 cycle.
- `led`/`buzzer` lag the engine inputs by 1 cycle.
- Reset values: state=MENU, `mode_en`=0, `song`=0, `difficulty`=0, `play_mod`=0, `cue_req`=0, `cue_idx`=0, `led`=0, `buzzer`=0, `sys_clock`=0, divider=0, table=identity, `trans_note`=0.
- Reset mid-REMAP: the table returns to identity.

## Structure
- Shared package: state encodings, song codes (0 = none), and the key-width constant.
- Sub-module `edge_pulse`, instantiated four times.
- Remap table: a register array inside the block, not RAM; no RAM dependency.

## Test plan
- Reset, then submit with `note_key`=0000001 (mode 0, `NEEDS_SONG[0]`=0) -> `mode_en`=0001 two cycles later; cancel -> `mode_en`=0000, state=MENU.
- Enter mode 3, press `oct_up` ×5 -> difficulty saturates at 6. Then submit with key 0000010 and `length_key`=0000100 -> song=2, `play_mod`=2, state=RUN.
- REMAP: submit keys 6,5,4,3,2,1,0 in order -> `cue_idx` 0..6. Then key 0 pressed -> `trans_note`=1000000 one cycle later; state returns to MENU.
- REMAP: press key 2 twice -> one write, one `cue_req` only. Then `remap_clear` -> identity map restored.
- Submit and cancel in the same cycle while in RUN -> MENU. Assert `rst_n` low mid-REMAP -> all outputs at reset values immediately.
- `TICK_DIV`=4: `sys_clock` increments every 4 cycles and wraps at 2^`CLOCK_BITS`.

Source files
------------

// File: rtl/piano_mode_sequencer_pkg.sv
// Shared types and constants for the piano mode sequencer.
// State encodings, song codes and key-width helpers.
package piano_mode_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_MENU   = 2'd0,
      ST_SELECT = 2'd1,
      ST_RUN    = 2'd2,
      ST_REMAP  = 2'd3
   } state_t;

   localparam int KEY_W     = 7;
   localparam int SONG_NONE = 0;

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/piano_mode_sequencer_if.sv
// Board-side and engine-side signal bundle of the mode sequencer.
// master drives board/engine inputs; slave is the sequencer.
interface piano_mode_sequencer_if
   import piano_mode_sequencer_pkg::*;
#(
   parameter int N_MODES    = 4,
   parameter int NOTE_KEYS  = KEY_W,
   parameter int N_SONGS    = 2,
   parameter int DIFF_MAX   = 6,
   parameter int CLOCK_BITS = 32
);
   localparam int SONG_W = $clog2(N_SONGS + 1);
   localparam int DIFF_W = $clog2(DIFF_MAX + 1);
   localparam int IDX_W  = clog2_min1(NOTE_KEYS);

   logic                         submit;
   logic                         cancel;
   logic                         oct_up;
   logic                         oct_down;
   logic [NOTE_KEYS-1:0]         note_key;
   logic [NOTE_KEYS-1:0]         length_key;
   logic                         remap_clear;
   logic [N_MODES-1:0]           mode_buzzer;
   logic [N_MODES*NOTE_KEYS-1:0] mode_led;
   logic                         cue_buzzer;

   logic [N_MODES-1:0]           mode_en;
   logic [SONG_W-1:0]            song;
   logic [DIFF_W-1:0]            difficulty;
   logic [1:0]                   play_mod;
   logic [NOTE_KEYS-1:0]         trans_note;
   logic                         cue_req;
   logic [IDX_W-1:0]             cue_idx;
   logic [1:0]                   state;
   logic [CLOCK_BITS-1:0]        sys_clock;
   logic [NOTE_KEYS-1:0]         led;
   logic                         buzzer;

   modport master (
      output submit, cancel, oct_up, oct_down,
      output note_key, length_key, remap_clear,
      output mode_buzzer, mode_led, cue_buzzer,
      input  mode_en, song, difficulty, play_mod,
      input  trans_note, cue_req, cue_idx, state,
      input  sys_clock, led, buzzer
   );

   modport slave (
      input  submit, cancel, oct_up, oct_down,
      input  note_key, length_key, remap_clear,
      input  mode_buzzer, mode_led, cue_buzzer,
      output mode_en, song, difficulty, play_mod,
      output trans_note, cue_req, cue_idx, state,
      output sys_clock, led, buzzer
   );

endinterface

// File: rtl/piano_mode_sequencer_edge_pulse.sv
// Rising-edge detector: one registered pulse per low-to-high level change.
module edge_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_pulse
);

   logic r_prev;
   logic r_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= i_level;
         r_pulse <= i_level & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/piano_mode_sequencer.sv
// Top-level mode sequencer: menu FSM, song/difficulty select,
// key-remap learning, LED/buzzer mux and the system tick.
module piano_mode_sequencer
   import piano_mode_sequencer_pkg::*;
#(
   parameter int                 N_MODES    = 4,
   parameter logic [N_MODES-1:0] NEEDS_SONG = 4'b1110,
   parameter int                 NOTE_KEYS  = KEY_W,
   parameter int                 N_SONGS    = 2,
   parameter int                 DIFF_MAX   = 6,
   parameter int                 TICK_DIV   = 100000,
   parameter int                 CLOCK_BITS = 32
) (
   input logic clk,
   input logic rst_n,
   piano_mode_sequencer_if.slave bus
);

   localparam int MODE_W = clog2_min1(N_MODES);
   localparam int IDX_W  = clog2_min1(NOTE_KEYS);
   localparam int CNT_W  = $clog2(NOTE_KEYS + 1);
   localparam int SONG_W = $clog2(N_SONGS + 1);
   localparam int DIFF_W = $clog2(DIFF_MAX + 1);
   localparam int DIV_W  = clog2_min1(TICK_DIV);

   logic w_sub, w_can, w_up, w_dn;

   edge_pulse u_sub (.clk(clk), .rst_n(rst_n),
                     .i_level(bus.submit), .o_pulse(w_sub));
   edge_pulse u_can (.clk(clk), .rst_n(rst_n),
                     .i_level(bus.cancel), .o_pulse(w_can));
   edge_pulse u_up  (.clk(clk), .rst_n(rst_n),
                     .i_level(bus.oct_up), .o_pulse(w_up));
   edge_pulse u_dn  (.clk(clk), .rst_n(rst_n),
                     .i_level(bus.oct_down), .o_pulse(w_dn));

   state_t               r_state, w_next;
   logic [MODE_W-1:0]    r_mode, w_mode;
   logic [N_MODES-1:0]   r_mode_en, w_mode_en;
   logic [SONG_W-1:0]    r_song, w_song;
   logic [DIFF_W-1:0]    r_diff, w_diff;
   logic [1:0]           r_pmod, w_pmod;
   logic                 r_cue_req, w_cue_req;
   logic [IDX_W-1:0]     r_cue_idx, w_cue_idx;
   logic [CNT_W-1:0]     r_cnt, w_cnt;
   logic [NOTE_KEYS-1:0] r_mask, w_mask;
   logic [IDX_W-1:0]     r_table [NOTE_KEYS];
   logic                 w_wr_en, w_tbl_clr;
   logic [NOTE_KEYS-1:0] r_trans, w_trans;
   logic [NOTE_KEYS-1:0] r_led, w_led;
   logic                 r_buzzer, w_buzzer;
   logic [DIV_W-1:0]     r_div;
   logic [CLOCK_BITS-1:0] r_sys;

   logic             w_onehot, w_sub_ok;
   logic [IDX_W-1:0] w_idx;
   logic             w_is_mode, w_is_remap, w_is_song;
   logic             w_needs;
   logic [1:0]       w_lmod;

   // Key decode; multi-key chords never count as a selection
   always_comb begin
      w_onehot = $onehot(bus.note_key);
      w_idx    = '0;
      for (int i = 0; i < NOTE_KEYS; i++)
         if (bus.note_key[i]) w_idx = IDX_W'(i);
      w_is_mode  = 32'(w_idx) < N_MODES;
      w_is_remap = 32'(w_idx) == N_MODES;
      w_is_song  = 32'(w_idx) < N_SONGS;
      w_needs    = 1'b0;
      for (int i = 0; i < N_MODES; i++)
         if (32'(w_idx) == i) w_needs = NEEDS_SONG[i];
      w_lmod = 2'd0;
      if ($onehot(bus.length_key))
         for (int k = 0; k < 4; k++)
            if (bus.length_key[k]) w_lmod = 2'(k);
   end

   assign w_sub_ok = w_sub & ~w_can & w_onehot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_MENU;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_MENU: begin
            if (w_sub_ok && w_is_mode)
               w_next = w_needs ? ST_SELECT : ST_RUN;
            else if (w_sub_ok && w_is_remap)
               w_next = ST_REMAP;
         end
         ST_SELECT: begin
            if (w_can)
               w_next = ST_MENU;
            else if (w_sub_ok && w_is_song)
               w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_can) w_next = ST_MENU;
         end
         ST_REMAP: begin
            if (w_can || bus.remap_clear ||
                32'(r_cnt) == NOTE_KEYS)
               w_next = ST_MENU;
         end
         default: w_next = ST_MENU;
      endcase
   end

   always_comb begin
      w_mode    = r_mode;
      w_song    = r_song;
      w_diff    = r_diff;
      w_pmod    = r_pmod;
      w_cue_req = 1'b0;
      w_cue_idx = r_cue_idx;
      w_cnt     = r_cnt;
      w_mask    = r_mask;
      w_wr_en   = 1'b0;
      w_tbl_clr = 1'b0;
      unique case (r_state)
         ST_MENU: begin
            if (w_sub_ok && w_is_mode) begin
               w_mode = MODE_W'(w_idx);
               if (w_needs) w_diff = DIFF_W'(DIFF_MAX / 2);
            end else if (w_sub_ok && w_is_remap) begin
               w_cnt  = '0;
               w_mask = '0;
            end
         end
         ST_SELECT: begin
            if (w_up && !w_dn && 32'(r_diff) < DIFF_MAX)
               w_diff = r_diff + 1'b1;
            else if (w_dn && !w_up && r_diff != '0)
               w_diff = r_diff - 1'b1;
            if (w_sub_ok && w_is_song) begin
               w_song = SONG_W'(32'(w_idx) + 1);
               w_pmod = w_lmod;
            end
         end
         ST_RUN: begin
            w_mode = r_mode;
         end
         ST_REMAP: begin
            if (bus.remap_clear) begin
               w_tbl_clr = 1'b1;
            end else if (w_sub_ok && 32'(r_cnt) < NOTE_KEYS &&
                         !r_mask[w_idx]) begin
               w_wr_en        = 1'b1;
               w_mask[w_idx]  = 1'b1;
               w_cue_req      = 1'b1;
               w_cue_idx      = IDX_W'(r_cnt);
               w_cnt          = r_cnt + 1'b1;
            end
         end
         default: w_mode = r_mode;
      endcase
      if (w_can && r_state != ST_MENU) w_song = '0;
      w_mode_en = '0;
      if (w_next == ST_RUN)
         for (int i = 0; i < N_MODES; i++)
            if (32'(w_mode) == i) w_mode_en[i] = 1'b1;
   end

   // Display mux follows the current state, one cycle behind engines
   always_comb begin
      w_led    = '0;
      w_buzzer = 1'b0;
      unique case (r_state)
         ST_SELECT: begin
            for (int i = 0; i < NOTE_KEYS; i++)
               w_led[i] = (32'(r_diff) == i);
         end
         ST_RUN: begin
            for (int i = 0; i < N_MODES; i++)
               if (32'(r_mode) == i) begin
                  w_led    = bus.mode_led[i*NOTE_KEYS +: NOTE_KEYS];
                  w_buzzer = bus.mode_buzzer[i];
               end
         end
         ST_REMAP: begin
            w_led    = r_mask;
            w_buzzer = bus.cue_buzzer;
         end
         default: w_led = '0;
      endcase
      w_trans = '0;
      for (int p = 0; p < NOTE_KEYS; p++)
         for (int q = 0; q < NOTE_KEYS; q++)
            if (bus.note_key[p] && 32'(r_table[p]) == q)
               w_trans[q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= '0;
         r_mode_en <= '0;
         r_song    <= SONG_W'(SONG_NONE);
         r_diff    <= '0;
         r_pmod    <= '0;
         r_cue_req <= 1'b0;
         r_cue_idx <= '0;
         r_cnt     <= '0;
         r_mask    <= '0;
         r_trans   <= '0;
         r_led     <= '0;
         r_buzzer  <= 1'b0;
      end else begin
         r_mode    <= w_mode;
         r_mode_en <= w_mode_en;
         r_song    <= w_song;
         r_diff    <= w_diff;
         r_pmod    <= w_pmod;
         r_cue_req <= w_cue_req;
         r_cue_idx <= w_cue_idx;
         r_cnt     <= w_cnt;
         r_mask    <= w_mask;
         r_trans   <= w_trans;
         r_led     <= w_led;
         r_buzzer  <= w_buzzer;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NOTE_KEYS; i++)
            r_table[i] <= IDX_W'(i);
      end else if (w_tbl_clr) begin
         for (int i = 0; i < NOTE_KEYS; i++)
            r_table[i] <= IDX_W'(i);
      end else if (w_wr_en) begin
         r_table[w_idx] <= IDX_W'(r_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_sys <= '0;
      end else if (32'(r_div) == TICK_DIV - 1) begin
         r_div <= '0;
         r_sys <= r_sys + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign bus.mode_en    = r_mode_en;
   assign bus.song       = r_song;
   assign bus.difficulty = r_diff;
   assign bus.play_mod   = r_pmod;
   assign bus.trans_note = r_trans;
   assign bus.cue_req    = r_cue_req;
   assign bus.cue_idx    = r_cue_idx;
   assign bus.state      = r_state;
   assign bus.sys_clock  = r_sys;
   assign bus.led        = r_led;
   assign bus.buzzer     = r_buzzer;

endmodule

// File: tb/tb_piano_mode_sequencer.sv
// Directed bench for piano_mode_sequencer with hand-computed expectations.
module tb_piano_mode_sequencer;
   import piano_mode_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   piano_mode_sequencer_if #(
      .N_MODES(4), .NOTE_KEYS(7), .N_SONGS(2),
      .DIFF_MAX(6), .CLOCK_BITS(4)
   ) bus ();

   piano_mode_sequencer #(
      .N_MODES(4), .NEEDS_SONG(4'b1110), .NOTE_KEYS(7),
      .N_SONGS(2), .DIFF_MAX(6), .TICK_DIV(4), .CLOCK_BITS(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [6:0] key, input logic [6:0] lkey);
      bus.note_key   = key;
      bus.length_key = lkey;
      bus.submit     = 1'b1;
      tick(1);
      bus.submit     = 1'b0;
      tick(1);
   endtask

   task automatic press_cancel();
      bus.cancel = 1'b1;
      tick(1);
      bus.cancel = 1'b0;
      tick(1);
   endtask

   task automatic press_oct(input logic up, input logic dn);
      bus.oct_up   = up;
      bus.oct_down = dn;
      tick(1);
      bus.oct_up   = 1'b0;
      bus.oct_down = 1'b0;
      tick(1);
   endtask

   initial begin
      bus.submit      = 1'b0;
      bus.cancel      = 1'b0;
      bus.oct_up      = 1'b0;
      bus.oct_down    = 1'b0;
      bus.note_key    = '0;
      bus.length_key  = '0;
      bus.remap_clear = 1'b0;
      bus.mode_buzzer = '0;
      bus.mode_led    = '0;
      bus.cue_buzzer  = 1'b0;

      tick(2);
      check("rst_state", 32'(bus.state), 0);
      check("rst_mode_en", 32'(bus.mode_en), 0);
      check("rst_song", 32'(bus.song), 0);
      check("rst_diff", 32'(bus.difficulty), 0);
      check("rst_led", 32'(bus.led), 0);
      check("rst_trans", 32'(bus.trans_note), 0);
      check("rst_sys", 32'(bus.sys_clock), 0);

      // System tick: 4 cycles per count, 4-bit wrap
      rst_n = 1'b1;
      tick(3);
      check("sys_3cyc", 32'(bus.sys_clock), 0);
      tick(1);
      check("sys_4cyc", 32'(bus.sys_clock), 1);
      tick(4);
      check("sys_8cyc", 32'(bus.sys_clock), 2);
      tick(52);
      check("sys_60cyc", 32'(bus.sys_clock), 15);
      tick(4);
      check("sys_wrap", 32'(bus.sys_clock), 0);

      // Mode 0 goes straight to RUN
      bus.mode_led    = {7'h55, 7'h2A, 7'h0F, 7'h33};
      bus.mode_buzzer = 4'b0001;
      press(7'b0000001, 7'b0);
      check("m0_state", 32'(bus.state), 2);
      check("m0_mode_en", 32'(bus.mode_en), 4'b0001);
      tick(1);
      check("m0_led", 32'(bus.led), 7'h33);
      check("m0_buzzer", 32'(bus.buzzer), 1);
      press_cancel();
      check("cancel_state", 32'(bus.state), 0);
      check("cancel_mode_en", 32'(bus.mode_en), 0);

      // Ignored submits in MENU
      press(7'b0000011, 7'b0);
      check("multi_key_ignored", 32'(bus.state), 0);
      press(7'b0100000, 7'b0);
      check("key5_ignored", 32'(bus.state), 0);

      // Mode 3 needs a song
      press(7'b0001000, 7'b0);
      check("m3_state", 32'(bus.state), 1);
      check("m3_diff_init", 32'(bus.difficulty), 3);
      tick(1);
      check("sel_led_diff3", 32'(bus.led), 7'b0001000);
      for (int i = 0; i < 5; i++) press_oct(1'b1, 1'b0);
      check("diff_sat_hi", 32'(bus.difficulty), 6);
      check("sel_led_diff6", 32'(bus.led), 7'b1000000);
      press_oct(1'b0, 1'b1);
      check("diff_down", 32'(bus.difficulty), 5);
      press_oct(1'b1, 1'b1);
      check("diff_both", 32'(bus.difficulty), 5);
      press(7'b0000010, 7'b0000100);
      check("sel_state", 32'(bus.state), 2);
      check("sel_song", 32'(bus.song), 2);
      check("sel_play_mod", 32'(bus.play_mod), 2);
      check("sel_mode_en", 32'(bus.mode_en), 4'b1000);
      tick(1);
      check("m3_led", 32'(bus.led), 7'h55);
      check("m3_buzzer", 32'(bus.buzzer), 0);

      // Submit and cancel together in RUN
      bus.note_key = 7'b0000001;
      bus.submit   = 1'b1;
      bus.cancel   = 1'b1;
      tick(1);
      bus.submit   = 1'b0;
      bus.cancel   = 1'b0;
      tick(1);
      check("subcan_state", 32'(bus.state), 0);
      check("subcan_mode_en", 32'(bus.mode_en), 0);
      check("subcan_song", 32'(bus.song), 0);

      // Full remap, reversed order
      bus.cue_buzzer = 1'b1;
      press(7'b0010000, 7'b0);
      check("remap_state", 32'(bus.state), 3);
      for (int k = 6; k >= 0; k--) begin
         press(7'(1 << k), 7'b0);
         check("remap_cue_req", 32'(bus.cue_req), 1);
         check("remap_cue_idx", 32'(bus.cue_idx), 6 - k);
         if (k == 6) check("remap_buzzer", 32'(bus.buzzer), 1);
      end
      tick(1);
      check("remap_done_state", 32'(bus.state), 0);
      check("remap_cue_off", 32'(bus.cue_req), 0);
      check("trans_key0", 32'(bus.trans_note), 7'b1000000);
      bus.note_key = 7'b1000001;
      tick(1);
      check("trans_key0_6", 32'(bus.trans_note), 7'b1000001);
      bus.note_key = 7'b0000100;
      tick(1);
      check("trans_key2", 32'(bus.trans_note), 7'b0010000);

      // Duplicate key, then clear
      press(7'b0010000, 7'b0);
      press(7'b0000100, 7'b0);
      check("dup_first_cue", 32'(bus.cue_req), 1);
      check("dup_first_idx", 32'(bus.cue_idx), 0);
      press(7'b0000100, 7'b0);
      check("dup_second_cue", 32'(bus.cue_req), 0);
      check("dup_trans", 32'(bus.trans_note), 7'b0000001);
      press(7'b0000001, 7'b0);
      check("next_cue", 32'(bus.cue_req), 1);
      check("next_cue_idx", 32'(bus.cue_idx), 1);
      tick(1);
      check("remap_led_mask", 32'(bus.led), 7'b0000101);
      check("next_trans", 32'(bus.trans_note), 7'b0000010);
      bus.remap_clear = 1'b1;
      tick(1);
      bus.remap_clear = 1'b0;
      check("clear_state", 32'(bus.state), 0);
      tick(1);
      check("clear_trans0", 32'(bus.trans_note), 7'b0000001);
      bus.note_key = 7'b0000100;
      tick(1);
      check("clear_trans2", 32'(bus.trans_note), 7'b0000100);

      // Reset in the middle of a remap
      press(7'b0010000, 7'b0);
      press(7'b0001000, 7'b0);
      check("pre_rst_cue", 32'(bus.cue_req), 1);
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(bus.state), 0);
      check("arst_cue_req", 32'(bus.cue_req), 0);
      check("arst_led", 32'(bus.led), 0);
      check("arst_buzzer", 32'(bus.buzzer), 0);
      check("arst_trans", 32'(bus.trans_note), 0);
      check("arst_diff", 32'(bus.difficulty), 0);
      check("arst_play_mod", 32'(bus.play_mod), 0);
      check("arst_sys", 32'(bus.sys_clock), 0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      check("arst_identity", 32'(bus.trans_note), 7'b0001000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
